core_mem_interface: RTL and testbench
=====================================

CORE_MEM_INTERFACE -- requirements
Module: core_mem_interface

Interface
REQ-001 Parameter ADDR_W, default 16, address width of every port.
REQ-002 Parameter DATA_W, default 16, data width of every port.
REQ-003 Parameter TIMEOUT, default 15, maximum BUSY cycles awaiting mem_ack, range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-007 if_addr  input  ADDR_W  fetch address, stable while if_req high.
REQ-008 if_rdata  output  DATA_W  fetched word, valid when if_ack high.
REQ-009 if_ack  output  1  one-cycle fetch completion pulse.
REQ-010 d_req  input  1  data-port request, held until d_ack.
REQ-011 d_we  input  1  data-port write enable: 1 write, 0 read.
REQ-012 d_addr  input  ADDR_W  data address.
REQ-013 d_wdata  input  DATA_W  write data.
REQ-014 d_rdata  output  DATA_W  read data, valid when d_ack high after a read.
REQ-015 d_ack  output  1  one-cycle data completion pulse.
REQ-016 err  output  1  high with the ack pulse of a timed-out transaction.
REQ-017 stall  output  1  core stall: (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
REQ-018 mem_req, mem_we  output  1  external memory request and write enable.
REQ-019 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  registered transaction payload.
REQ-020 mem_rdata  input  DATA_W; mem_ack  input  1  memory data and completion, variable latency.

Function
REQ-021 FSM states IDLE, BUSY, DONE; only IDLE arbitrates.
REQ-022 IDLE: any request pending -> grant, latch addr/we/wdata/owner, -> BUSY; none -> stay IDLE.
REQ-023 Both requests pending in IDLE: data port wins (fixed priority unless REQ-036).
REQ-024 BUSY: mem_req=1, mem_addr/mem_we/mem_wdata driven from latched payload, constant for the whole BUSY period.
REQ-025 BUSY with mem_ack=1 -> DONE; owner read data captured from mem_rdata on that edge.
REQ-026 DONE: owner ack=1 for exactly one cycle, mem_req=0, -> IDLE; no arbitration in DONE.
REQ-027 Latency: request seen at edge N -> mem_req from cycle N+1; zero-wait mem_ack -> ack in cycle N+2.
REQ-028 Writes leave d_rdata unchanged; if_rdata/d_rdata hold last captured value between acks.
REQ-029 Timeout counter cleared on BUSY entry, +1 per BUSY cycle without mem_ack; reaching TIMEOUT -> DONE with err=1, owner rdata = all ones, mem_req dropped.
REQ-030 mem_ack outside BUSY ignored; mem_ack on the timeout cycle is treated as success (err=0).
REQ-031 Request withdrawn during BUSY: transaction still completes, ack still pulses.
REQ-032 err=0 in every cycle except an erroring DONE.

Reset
REQ-033 rst low asynchronously forces IDLE, mem_req=0, mem_we=0, if_ack=0, d_ack=0, err=0, timeout counter 0, round-robin pointer to data port.
REQ-034 mem_addr, mem_wdata, if_rdata, d_rdata reset to 0.
REQ-035 Reset mid-BUSY aborts without ack; first post-reset grant follows REQ-022.

Configuration
REQ-036 Macro CORE_MEM_RR_EN defined: simultaneous requests granted round-robin, alternating from the port not granted last; single requests unaffected.
REQ-037 CORE_MEM_RR_EN undefined: fixed data-over-fetch priority per REQ-023; no pointer register.

Verification
REQ-038 if_req=1, if_addr=0x0010, mem_ack same cycle as mem_req, mem_rdata=0xA5A5 -> if_ack in cycle 2, if_rdata=0xA5A5, err=0.
REQ-039 d_req=1, d_we=1, d_addr=0x0100, d_wdata=0x1234, mem_ack after 3 cycles -> mem_we=1, mem_wdata=0x1234 for 3 cycles, d_ack one pulse, d_rdata unchanged.
REQ-040 if_req and d_req together, back-to-back zero-wait -> default: data then fetch; with CORE_MEM_RR_EN: data, fetch, data, fetch over 4 transactions.
REQ-041 d_req read, mem_ack never asserted, TIMEOUT=15 -> d_ack with err=1, d_rdata=0xFFFF after 15 BUSY cycles, mem_req low afterwards.
REQ-042 rst low during BUSY -> all outputs at reset values immediately, no ack pulse; new fetch after release completes normally.

Source files
------------

// File: rtl/core_mem_interface.sv
// Arbitrates an instruction-fetch port and a data port onto one variable-latency memory bus.
// Define CORE_MEM_RR_EN for round-robin arbitration of simultaneous requests (default: data wins).
module core_mem_interface #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_reg;
  logic              owner_d_reg;
  logic              we_reg;
  logic              err_reg;
  logic [7:0]        cnt_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;
  logic              grant_d;

`ifdef CORE_MEM_RR_EN
  // Set means the data port takes the next simultaneous request.
  logic prio_d_reg;

  assign grant_d = d_req & (~if_req | prio_d_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_d_reg <= 1'b1;
    end else if (state_reg == IDLE && (if_req || d_req)) begin
      prio_d_reg <= ~grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      owner_d_reg   <= 1'b0;
      we_reg        <= 1'b0;
      err_reg       <= 1'b0;
      cnt_reg       <= 8'd0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (if_req || d_req) begin
            state_reg    <= BUSY;
            owner_d_reg  <= grant_d;
            we_reg       <= grant_d & d_we;
            mem_addr_reg <= grant_d ? d_addr : if_addr;
            cnt_reg      <= 8'd0;
            if (grant_d) mem_wdata_reg <= d_wdata;
          end
        end
        BUSY: begin
          // A late mem_ack on the final allowed cycle still counts as success.
          if (mem_ack) begin
            state_reg <= DONE;
            err_reg   <= 1'b0;
            if (!owner_d_reg)  if_rdata_reg <= mem_rdata;
            else if (!we_reg)  d_rdata_reg  <= mem_rdata;
          end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
            state_reg <= DONE;
            err_reg   <= 1'b1;
            if (!owner_d_reg)  if_rdata_reg <= '1;
            else if (!we_reg)  d_rdata_reg  <= '1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          err_reg   <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req   = (state_reg == BUSY);
  assign mem_we    = mem_req & we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign if_ack    = (state_reg == DONE) & ~owner_d_reg;
  assign d_ack     = (state_reg == DONE) & owner_d_reg;
  assign err       = err_reg;
  assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_core_mem_interface.sv
// Self-checking bench for core_mem_interface: directed cases plus randomized transactions
// checked against a transaction-level model of grant order, latency and returned data.
module tb_core_mem_interface;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ack;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, err, stall, mem_req, mem_we;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_if = 16'h0;
  logic [15:0] exp_d  = 16'h0;
  bit          prio_d = 1'b1;

  always #5 clk = ~clk;

  core_mem_interface #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One transaction from request to ack, then one idle cycle. Called at a negedge.
  task automatic run_txn(input bit i_on, input bit d_on, input bit we,
                         input logic [15:0] ia, input logic [15:0] da,
                         input logic [15:0] wd, input logic [15:0] rd,
                         input int lat, input bit to, input bit wdr, output bit win_d);
    int ack_c;
    logic [15:0] val;
`ifdef CORE_MEM_RR_EN
    win_d  = d_on & (~i_on | prio_d);
    prio_d = ~win_d;
`else
    win_d = d_on;
`endif
    ack_c   = to ? TO + 1 : lat + 2;
    if_req  = i_on; if_addr = ia;
    d_req   = d_on; d_we = we; d_addr = da; d_wdata = wd;
    mem_ack = 1'b0;
    for (int c = 1; c <= ack_c; c++) begin
      @(negedge clk);
      if (c < ack_c) begin
        chk("busy_mem_req", mem_req, 1);
        chk("busy_mem_addr", mem_addr, win_d ? da : ia);
        chk("busy_mem_we", mem_we, win_d & we);
        if (win_d && we) chk("busy_mem_wdata", mem_wdata, wd);
        chk("busy_ack_err", {if_ack, d_ack, err}, 0);
        chk("busy_stall", stall, if_req | d_req);
        if (wdr && c == 1) begin
          if (win_d) d_req = 1'b0; else if_req = 1'b0;
        end
        mem_ack   = (!to && c == lat + 1);
        mem_rdata = mem_ack ? rd : 16'($urandom);
      end else begin
        if (!(win_d && we)) begin
          val = to ? 16'hFFFF : rd;
          if (win_d) exp_d = val; else exp_if = val;
        end
        chk("if_ack", if_ack, !win_d);
        chk("d_ack", d_ack, win_d);
        chk("err", err, to);
        chk("done_mem_req", mem_req, 0);
        chk("if_rdata", if_rdata, exp_if);
        chk("d_rdata", d_rdata, exp_d);
        chk("done_stall", stall, (if_req & win_d) | (d_req & ~win_d));
        $display("txn owner=%s we=%0d addr=%h lat=%0d to=%0d if_rdata=%h d_rdata=%h err=%0d",
                 win_d ? "data" : "fetch", win_d & we, win_d ? da : ia, lat, to,
                 if_rdata, d_rdata, err);
        if (win_d) d_req = 1'b0; else if_req = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
    end
    @(negedge clk);
    chk("gap_idle", {if_ack, d_ack, err, mem_req}, 0);
    mem_ack = 1'b0;
  endtask

  initial begin
    bit w, w2;
    bit i_on, d_on, we, to, wdr;
    logic [15:0] ia, da, wd;
    int mask;

    rst = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {mem_req, mem_we, if_ack, d_ack, err, stall}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait fetch.
    run_txn(1, 0, 0, 16'h0010, 16'h0, 16'h0, 16'hA5A5, 0, 0, 0, w);
    // Write with a three-cycle memory wait: d_rdata must not move.
    run_txn(0, 1, 1, 16'h0, 16'h0100, 16'h1234, 16'hDEAD, 2, 0, 0, w);
    // Simultaneous requests, then the pending loser.
    run_txn(1, 1, 0, 16'h0020, 16'h0030, 16'h0, 16'h1111, 0, 0, 0, w);
    if (w) run_txn(1, 0, 0, 16'h0020, 16'h0030, 16'h0, 16'h2222, 0, 0, 0, w2);
    else   run_txn(0, 1, 0, 16'h0020, 16'h0030, 16'h0, 16'h2222, 0, 0, 0, w2);
    // Data read that never gets mem_ack.
    run_txn(0, 1, 0, 16'h0, 16'h0200, 16'h0, 16'h0, 0, 1, 0, w);
    // mem_ack on the last allowed cycle is a success.
    run_txn(1, 0, 0, 16'h0300, 16'h0, 16'h0, 16'h5A5A, TO - 1, 0, 0, w);
    // Requester withdraws during BUSY.
    run_txn(0, 1, 0, 16'h0, 16'h0400, 16'h0, 16'hBEEF, 3, 0, 1, w);

    // Reset in the middle of a fetch.
    if_req = 1'b1; if_addr = 16'h0055; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", {mem_req, mem_we, if_ack, d_ack, err}, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_rdata", {if_rdata, d_rdata}, 0);
    exp_if = 16'h0; exp_d = 16'h0; prio_d = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    chk("midrst_no_ack", {if_ack, d_ack}, 0);
    rst = 1'b1;
    @(negedge clk);
    run_txn(1, 0, 0, 16'h0066, 16'h0, 16'h0, 16'hC3C3, 1, 0, 0, w);

    for (int n = 0; n < 30; n++) begin
      mask = $urandom_range(1, 3);
      i_on = mask[0]; d_on = mask[1];
      we   = 1'($urandom_range(0, 1));
      ia   = 16'($urandom); da = 16'($urandom); wd = 16'($urandom);
      to   = ($urandom_range(0, 9) == 0);
      wdr  = (mask != 3) && ($urandom_range(0, 7) == 0);
      run_txn(i_on, d_on, we, ia, da, wd, 16'($urandom), $urandom_range(0, 6), to, wdr, w);
      if (i_on && d_on) begin
        if (w) run_txn(1, 0, we, ia, da, wd, 16'($urandom), $urandom_range(0, 6), 0, 0, w2);
        else   run_txn(0, 1, we, ia, da, wd, 16'($urandom), $urandom_range(0, 6), 0, 0, w2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
